// File: rtl/inj_patgen_multi_pkg.sv
// -----------------------------------------------------------------------------
// inj_patgen_pkg
// Shared definitions for the multi-channel injection pattern generator:
//   - FSM state encoding
//   - byte addresses of the configuration register map
//   - byte count of one multi-byte timing field
// -----------------------------------------------------------------------------
package inj_patgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_DELAY,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

  // Each timing field occupies FIELD_BYTES consecutive addresses, little-endian.
  localparam int FIELD_BYTES = 4;

  localparam logic [4:0] ADDR_PERIOD = 5'd0;
  localparam logic [4:0] ADDR_HIGH   = 5'd4;
  localparam logic [4:0] ADDR_NPULSE = 5'd8;
  localparam logic [4:0] ADDR_DELAY  = 5'd12;
  localparam logic [4:0] ADDR_MASK   = 5'd16;
  localparam logic [4:0] ADDR_INVERT = 5'd17;
  localparam logic [4:0] ADDR_CTRL   = 5'd18;

  // The train is "running" while it is timing delay, high or low phases.
  function automatic logic is_running(state_e s);
    return (s == ST_DELAY) || (s == ST_HIGH) || (s == ST_LOW);
  endfunction

endpackage

// File: rtl/inj_patgen_multi_if.sv
// -----------------------------------------------------------------------------
// inj_patgen_multi_if
// Bus bundle of the pattern generator.
//   master: register write port (write/addr/din), train control (suspend,
//           synced, sync_in); observes out/running/done/pulse_cnt.
//   slave : the generator itself.
// -----------------------------------------------------------------------------
interface inj_patgen_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic              suspend;
  logic              write;
  logic [4:0]        addr;
  logic [7:0]        din;
  logic              synced;
  logic              sync_in;
  logic [NUM_CH-1:0] out;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  pulse_cnt;

  modport master (
    output suspend, write, addr, din, synced, sync_in,
    input  out, running, done, pulse_cnt
  );

  modport slave (
    input  suspend, write, addr, din, synced, sync_in,
    output out, running, done, pulse_cnt
  );
endinterface

// File: rtl/inj_patgen_multi_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector. rise_o is a one-cycle pulse, valid two edges after the first clk
// edge that samples async_i high.
//   clk     : system clock
//   res_n   : asynchronous active-low reset
//   async_i : asynchronous input
//   rise_o  : synchronous rising-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic res_n,
  input  logic async_i,
  output logic rise_o
);
  // [0],[1] are the synchroniser stages, [2] is the previous synchronised value.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/inj_patgen_multi.sv
// -----------------------------------------------------------------------------
// inj_patgen_multi
// Multi-channel injection pattern generator. One pulse train (delay, high,
// period, pulse count) is gated by a channel mask and a per-channel polarity
// to drive NUM_CH chopper outputs. Free-running or sync-triggered start.
//   clk   : system clock
//   res_n : asynchronous active-low reset (clears everything)
//   rst   : synchronous soft reset (train to IDLE, registers kept)
//   bus   : slave side of inj_patgen_multi_if (register writes, control,
//           out/running/done/pulse_cnt)
// -----------------------------------------------------------------------------
module inj_patgen_multi
  import inj_patgen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 rst,
  inj_patgen_multi_if.slave    bus
);
  localparam int NBYTES = CNT_W / 8;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Configuration registers
  logic [CNT_W-1:0]  period_q, high_q, npulse_q, delay_q;
  logic [NUM_CH-1:0] mask_q, invert_q;

  // Shadow copies taken at start; the high/low split is resolved once here.
  logic [CNT_W-1:0]  hi_s_q, lo_s_q, np_s_q, dly_s_q;
  logic [CNT_W-1:0]  hi_len, lo_len;

  // Train state
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d, pcnt_inc;
  logic              done_q, done_d;
  logic              running_q;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_end;

  logic sync_rise;
  logic start_ok;

  sync_edge_detect u_sync (
    .clk     (clk),
    .res_n   (res_n),
    .async_i (bus.sync_in),
    .rise_o  (sync_rise)
  );

  // A start with period 0 is rejected outright and changes nothing.
  assign start_ok = bus.write && (bus.addr == ADDR_CTRL) && bus.din[0] &&
                    (period_q != '0);
  assign hi_len   = (high_q > period_q) ? period_q : high_q;
  assign lo_len   = period_q - hi_len;

  // Byte-wise register file; bytes beyond CNT_W/8 have no storage.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      // NOTE: configuration is a handful of flops, so all of it is reset.
      period_q <= '0;
      high_q   <= '0;
      npulse_q <= '0;
      delay_q  <= '0;
      mask_q   <= '0;
      invert_q <= '0;
    end else if (bus.write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.addr[1:0] == 2'(b)) begin
          case (bus.addr[4:2])
            ADDR_PERIOD[4:2]: period_q[8*b +: 8] <= bus.din;
            ADDR_HIGH[4:2]:   high_q[8*b +: 8]   <= bus.din;
            ADDR_NPULSE[4:2]: npulse_q[8*b +: 8] <= bus.din;
            ADDR_DELAY[4:2]:  delay_q[8*b +: 8]  <= bus.din;
            default: ;
          endcase
        end
      end
      if (bus.addr == ADDR_MASK)   mask_q   <= bus.din[NUM_CH-1:0];
      if (bus.addr == ADDR_INVERT) invert_q <= bus.din[NUM_CH-1:0];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hi_s_q  <= '0;
      lo_s_q  <= '0;
      np_s_q  <= '0;
      dly_s_q <= '0;
    end else if (start_ok && !rst) begin
      hi_s_q  <= hi_len;
      lo_s_q  <= lo_len;
      np_s_q  <= npulse_q;
      dly_s_q <= delay_q;
    end
  end

  // Next-state logic. DELAY lasts delay+1 cycles; HIGH and LOW last their
  // shadow lengths and a zero-length phase is skipped. suspend holds all.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    done_d     = done_q;
    period_end = 1'b0;
    pcnt_inc   = pcnt_q + ONE;

    if (rst) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      done_d  = 1'b0;
    end else if (start_ok) begin
      state_d = bus.synced ? ST_WAIT_SYNC : ST_DELAY;
      cnt_d   = '0;
      pcnt_d  = '0;
      done_d  = 1'b0;
    end else if (!bus.suspend) begin
      case (state_q)
        ST_WAIT_SYNC: begin
          if (sync_rise) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
          end
        end
        ST_DELAY: begin
          if (cnt_q == dly_s_q) begin
            cnt_d   = '0;
            state_d = (hi_s_q != '0) ? ST_HIGH : ST_LOW;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q == hi_s_q - ONE) begin
            cnt_d = '0;
            if (lo_s_q != '0) state_d = ST_LOW;
            else              period_end = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q == lo_s_q - ONE) begin
            cnt_d      = '0;
            period_end = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: ;
      endcase

      if (period_end) begin
        pcnt_d = pcnt_inc;
        if ((np_s_q != '0) && (pcnt_inc == np_s_q)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = (hi_s_q != '0) ? ST_HIGH : ST_LOW;
        end
      end
    end
  end

  // Output polarity: idle level is invert; pulse only on masked channels.
  always_comb begin
    out_d = invert_q;
    if (!rst && !bus.suspend && (state_q == ST_HIGH)) begin
      out_d = invert_q ^ mask_q;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
      running_q <= is_running(state_d);
      out_q     <= out_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pcnt_q;
endmodule

// File: tb/tb_inj_patgen_multi.sv
// -----------------------------------------------------------------------------
// tb_inj_patgen_multi
// Directed bench for inj_patgen_multi (NUM_CH=2, CNT_W=16). Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point. Cycle index k
// counts edges after the edge that sampled the start write.
// -----------------------------------------------------------------------------
module tb_inj_patgen_multi;
  import inj_patgen_pkg::*;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  inj_patgen_multi_if #(.NUM_CH(2), .CNT_W(16)) bus ();

  inj_patgen_multi #(.NUM_CH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .res_n (res_n),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
    bus.write = 1'b1;
    bus.addr  = a;
    bus.din   = d;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic program_train(input int per, input int hi, input int np, input int dly);
    logic [31:0] p, h, n, d;
    p = per; h = hi; n = np; d = dly;
    write_reg(5'd0,  p[7:0]);  write_reg(5'd1,  p[15:8]);
    write_reg(5'd4,  h[7:0]);  write_reg(5'd5,  h[15:8]);
    write_reg(5'd8,  n[7:0]);  write_reg(5'd9,  n[15:8]);
    write_reg(5'd12, d[7:0]);  write_reg(5'd13, d[15:8]);
    // Bytes above CNT_W/8 and unmapped addresses must have no effect.
    write_reg(5'd2,  8'hFF);   write_reg(5'd10, 8'hFF);
    write_reg(5'd19, 8'hFF);   write_reg(5'd31, 8'hFF);
  endtask

  task automatic start();
    write_reg(ADDR_CTRL, 8'h01);
  endtask

  // Reference pulse shape: high at k when (k-first) mod per < min(hi,per),
  // limited to n periods.
  function automatic bit exp_high(int k, int first, int per, int hi, int n);
    int h;
    h = (hi < per) ? hi : per;
    if (k < first) return 1'b0;
    if ((k - first) >= n * per) return 1'b0;
    return ((k - first) % per) < h;
  endfunction

  task automatic test_reset();
    res_n = 1'b0;
    tick(); tick();
    checks++; if (bus.out !== 2'b00) begin failures++; $display("FAIL reset_out got=%b exp=00", bus.out); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pulse_cnt !== 16'd0) begin failures++; $display("FAIL reset_pulse_cnt got=%0d exp=0", bus.pulse_cnt); end
    res_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_train();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    write_reg(ADDR_MASK, 8'h03);
    write_reg(ADDR_INVERT, 8'h00);
    program_train(10, 3, 4, 0);
    start();
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp = exp_high(k, 2, 10, 3, 4) ? 2'b11 : 2'b00;
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = k; bad_v = bus.out; end end
      if (k == 1) begin checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL basic_running_k1 got=%b exp=1", bus.running); end end
      if (k == 10) begin checks++; if (bus.pulse_cnt !== 16'd0) begin failures++; $display("FAIL basic_pcnt_k10 got=%0d exp=0", bus.pulse_cnt); end end
      if (k == 11) begin checks++; if (bus.pulse_cnt !== 16'd1) begin failures++; $display("FAIL basic_pcnt_k11 got=%0d exp=1", bus.pulse_cnt); end end
      if (k == 40) begin checks++; if (bus.done !== 1'b0 || bus.pulse_cnt !== 16'd3) begin failures++; $display("FAIL basic_k40 done=%b pcnt=%0d exp done=0 pcnt=3", bus.done, bus.pulse_cnt); end end
      if (k == 41) begin checks++; if (bus.done !== 1'b1 || bus.pulse_cnt !== 16'd4) begin failures++; $display("FAIL basic_k41 done=%b pcnt=%0d exp done=1 pcnt=4", bus.done, bus.pulse_cnt); end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL basic_waveform mismatches=%0d first_k=%0d got=%b", err, bad_k, bad_v); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL basic_running_end got=%b exp=0", bus.running); end
  endtask

  task automatic test_mask_invert();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    write_reg(ADDR_MASK, 8'h01);
    write_reg(ADDR_INVERT, 8'h02);
    tick();
    checks++; if (bus.out !== 2'b10) begin failures++; $display("FAIL maskinv_idle got=%b exp=10", bus.out); end
    start();
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp = {1'b1, exp_high(k, 2, 10, 3, 4)};
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = k; bad_v = bus.out; end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL maskinv_waveform mismatches=%0d first_k=%0d got=%b", err, bad_k, bad_v); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL maskinv_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_synced();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    write_reg(ADDR_MASK, 8'h03);
    write_reg(ADDR_INVERT, 8'h00);
    program_train(10, 3, 4, 5);
    bus.synced = 1'b1;
    // Stale edge before start: must not trigger the train.
    bus.sync_in = 1'b1; tick(); tick(); tick();
    bus.sync_in = 1'b0; tick(); tick(); tick(); tick(); tick();
    start();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.out !== 2'b00 || bus.running !== 1'b0) err++;
    end
    checks++; if (err != 0) begin failures++; $display("FAIL sync_wait_quiet cycles_active=%0d exp=0", err); end
    err = 0;
    bus.sync_in = 1'b1;
    tick();  // edge that first samples sync_in high (j=0)
    for (int j = 1; j <= 50; j++) begin
      if (j == 2) bus.sync_in = 1'b0;
      tick();
      exp = exp_high(j, 9, 10, 3, 4) ? 2'b11 : 2'b00;
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = j; bad_v = bus.out; end end
      if (j == 1) begin checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL sync_running_j1 got=%b exp=0", bus.running); end end
      if (j == 2) begin checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL sync_running_j2 got=%b exp=1", bus.running); end end
      if (j == 8) begin checks++; if (bus.out !== 2'b00) begin failures++; $display("FAIL sync_out_j8 got=%b exp=00", bus.out); end end
      if (j == 9) begin checks++; if (bus.out !== 2'b11) begin failures++; $display("FAIL sync_first_high_j9 got=%b exp=11", bus.out); end end
      if (j == 47) begin checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL sync_done_j47 got=%b exp=0", bus.done); end end
      if (j == 48) begin checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL sync_done_j48 got=%b exp=1", bus.done); end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL sync_waveform mismatches=%0d first_j=%0d got=%b", err, bad_k, bad_v); end
    bus.synced = 1'b0;
  endtask

  task automatic test_suspend();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    program_train(10, 3, 2, 0);
    start();
    for (int k = 1; k <= 35; k++) begin
      if (k == 3)  bus.suspend = 1'b1;   // edges 3..9 see suspend: 7 cycles
      if (k == 10) bus.suspend = 1'b0;
      tick();
      exp = (k == 2 || k == 10 || k == 11 || k == 19 || k == 20 || k == 21) ? 2'b11 : 2'b00;
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = k; bad_v = bus.out; end end
      if (k == 5) begin checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL susp_running_k5 got=%b exp=1", bus.running); end end
      if (k == 17) begin checks++; if (bus.pulse_cnt !== 16'd0) begin failures++; $display("FAIL susp_pcnt_k17 got=%0d exp=0", bus.pulse_cnt); end end
      if (k == 18) begin checks++; if (bus.pulse_cnt !== 16'd1) begin failures++; $display("FAIL susp_pcnt_k18 got=%0d exp=1", bus.pulse_cnt); end end
      if (k == 27) begin checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL susp_done_k27 got=%b exp=0", bus.done); end end
      if (k == 28) begin checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL susp_done_k28 got=%b exp=1", bus.done); end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL susp_waveform mismatches=%0d first_k=%0d got=%b", err, bad_k, bad_v); end
  endtask

  task automatic test_clamp_and_zero();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    program_train(10, 12, 3, 0);
    start();
    for (int k = 1; k <= 35; k++) begin
      tick();
      exp = (k >= 2 && k <= 31) ? 2'b11 : 2'b00;
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = k; bad_v = bus.out; end end
      if (k == 30) begin checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL clamp_done_k30 got=%b exp=0", bus.done); end end
      if (k == 31) begin checks++; if (bus.done !== 1'b1 || bus.pulse_cnt !== 16'd3) begin failures++; $display("FAIL clamp_k31 done=%b pcnt=%0d exp done=1 pcnt=3", bus.done, bus.pulse_cnt); end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL clamp_waveform mismatches=%0d first_k=%0d got=%b", err, bad_k, bad_v); end
    // period = 0: start is rejected, generator stays idle.
    rst = 1'b1; tick(); rst = 1'b0;
    program_train(0, 3, 4, 0);
    start();
    err = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.running !== 1'b0 || bus.out !== 2'b00 || bus.done !== 1'b0) err++;
    end
    checks++; if (err != 0) begin failures++; $display("FAIL period0_idle cycles_active=%0d exp=0", err); end
  endtask

  task automatic test_rst_resn();
    int err = 0; int bad_k = -1; logic [1:0] exp; logic [1:0] bad_v = '0;
    write_reg(ADDR_MASK, 8'h03);
    write_reg(ADDR_INVERT, 8'h01);
    program_train(10, 3, 0, 0);
    start();
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp = 2'b01 ^ (exp_high(k, 2, 10, 3, 1000) ? 2'b11 : 2'b00);
      if (bus.out !== exp) begin err++; if (bad_k < 0) begin bad_k = k; bad_v = bus.out; end end
    end
    checks++; if (err != 0) begin failures++; $display("FAIL rst_waveform mismatches=%0d first_k=%0d got=%b", err, bad_k, bad_v); end
    checks++; if (bus.pulse_cnt !== 16'd2 || bus.running !== 1'b1) begin failures++; $display("FAIL npulse0_k26 pcnt=%0d running=%b exp pcnt=2 running=1", bus.pulse_cnt, bus.running); end
    rst = 1'b1;
    tick();  // k=27, mid-LOW
    checks++; if (bus.running !== 1'b0 || bus.pulse_cnt !== 16'd0 || bus.done !== 1'b0 || bus.out !== 2'b01) begin
      failures++; $display("FAIL softrst running=%b pcnt=%0d done=%b out=%b exp 0/0/0/01", bus.running, bus.pulse_cnt, bus.done, bus.out);
    end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.running !== 1'b0 || bus.out !== 2'b01) begin failures++; $display("FAIL softrst_hold running=%b out=%b exp 0/01", bus.running, bus.out); end
    // Registers survive soft reset: a new start reproduces the train.
    start();
    tick();
    checks++; if (bus.running !== 1'b1 || bus.out !== 2'b01) begin failures++; $display("FAIL restart_k1 running=%b out=%b exp 1/01", bus.running, bus.out); end
    tick();
    checks++; if (bus.out !== 2'b10) begin failures++; $display("FAIL restart_k2 got=%b exp=10", bus.out); end
    // Hard reset in the middle of DELAY.
    write_reg(5'd12, 8'd6);
    start();
    tick(); tick(); tick();
    checks++; if (bus.running !== 1'b1 || bus.out !== 2'b01) begin failures++; $display("FAIL delay_k3 running=%b out=%b exp 1/01", bus.running, bus.out); end
    #2 res_n = 1'b0;
    #1;
    checks++; if (bus.out !== 2'b00 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.pulse_cnt !== 16'd0) begin
      failures++; $display("FAIL hardrst_async out=%b running=%b done=%b pcnt=%0d exp 00/0/0/0", bus.out, bus.running, bus.done, bus.pulse_cnt);
    end
    @(negedge clk);
    res_n = 1'b1;
    tick();
    // All registers cleared: period is 0, so this start is rejected.
    start();
    err = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.running !== 1'b0 || bus.out !== 2'b00) err++;
    end
    checks++; if (err != 0) begin failures++; $display("FAIL hardrst_regs_cleared cycles_active=%0d exp=0", err); end
  endtask

  initial begin
    bus.suspend = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.din     = '0;
    bus.synced  = 1'b0;
    bus.sync_in = 1'b0;
    test_reset();
    test_basic_train();
    test_mask_invert();
    test_synced();
    test_suspend();
    test_clamp_and_zero();
    test_rst_resn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
